ahb_sram_slave: RTL and testbench
=================================

Name: ahb_sram_slave

Overview:
- Parametrised, synthesizable AHB-Lite slave backed by an internal word-array memory with configurable wait states.
- Generalises the bus to DATA_W/ADDR_W and adds a two-cycle ERROR response plus a byte-lane write path.
- Sits behind the AHB decoder/mux; it is the default RTL target for agents using the master-side clocking block.

Parameters:
- ADDR_W, 32, HADDR width.
- DATA_W, 32, HWDATA/HRDATA width; legal values 32 or 64.
- DEPTH, 256, memory words of DATA_W bits; power of two.
- WAIT_STATES, 0, extra HREADYOUT-low cycles inserted per OKAY data phase; range 0..15.

Ports:
- HCLK  in  1  clock; all logic on the rising edge.
- HRST  in  1  reset; synchronous, active-high.
- HSEL  in  1  slave select from the decoder.
- HADDR  in  ADDR_W  byte address.
- HTRANS  in  2  IDLE=00, BUSY=01, NONSEQ=10, SEQ=11.
- HWRITE  in  1  1 = write.
- HSIZE  in  3  log2 of the transfer bytes.
- HBURST  in  3  accepted and ignored; each beat is decoded independently.
- HPROT  in  4  protection; used only with the optional feature.
- HWDATA  in  DATA_W  write data, valid in the data phase.
- HREADY  in  1  bus-level ready; the address phase is sampled only when HREADY=1.
- HRDATA  out  DATA_W  read data.
- HREADYOUT  out  1  this slave's ready.
- HRESP  out  2  OKAY=00, ERROR=01.

Behaviour:
- Reset:
  - HREADYOUT=1, HRESP=00, HRDATA=0, FSM=IDLE, wait counter=0.
  - Any pending write is dropped. Memory contents are not cleared.
  - Reset asserted mid data phase aborts that transfer; the next cycle behaves as fresh IDLE.
- Address-phase accept:
  - Condition: HSEL & HREADY & HTRANS[1].
  - On accept, register the address, write flag, size and byte-lane mask.
  - BUSY and IDLE transfers get a zero-wait OKAY and no memory access.
- Lane rules (LB = log2(DATA_W/8)):
  - lane = HADDR[LB-1:0]; little-endian.
  - Mask has 2^HSIZE bits, starting at bit lane.
- Error conditions, checked at accept, any one sufficient:
  - HSIZE > LB;
  - HADDR not aligned to 2^HSIZE;
  - word index HADDR[ADDR_W-1:LB] >= DEPTH.
- FSM states: IDLE, WAIT, ERR1, ERR2.
  - IDLE, on a valid accept: go to WAIT with counter=WAIT_STATES, or complete in the next cycle if WAIT_STATES=0.
  - IDLE, on an error accept: go to ERR1.
  - WAIT: HREADYOUT=0, decrement the counter. At 0, drive HREADYOUT=1, HRESP=OKAY, then return to IDLE or take the next accept.
  - ERR1: HREADYOUT=0, HRESP=01.
  - ERR2: HREADYOUT=1, HRESP=01. A new accept in this cycle is honoured.
- Write commit:
  - Lane-masked HWDATA is written to memory on the completing data-phase edge (HREADYOUT=1).
  - Errored writes never modify memory.
- Read data:
  - HRDATA = mem[registered index] during the completing cycle; full word on all lanes.
  - HRDATA=0 on error or idle responses.
- Back-to-back write(A) then read(A):
  - The read data phase follows the write commit, so the read returns the new value.
  - No forwarding is required.
- Pipelining: address phase N+1 overlaps data phase N. Throughput is one transfer per 1+WAIT_STATES cycles.
- HSEL=0 with HREADY=1: FSM stays in IDLE and outputs hold their idle values.

Optional Feature:
- Macro: AHB_SRAM_PROT_CHECK_EN.
- Defined:
  - The upper half of memory (index >= DEPTH/2) is privileged.
  - Any transfer there with HPROT[1]=0 takes the two-cycle ERROR response and no write occurs.
- Undefined: HPROT is ignored entirely; no extra logic is present.

Decomposition:
- Package ahb_pkg holds:
  - htrans_e (IDLE/BUSY/NONSEQ/SEQ);
  - hresp_e (OKAY/ERROR);
  - hsize_e (BYTE..DWORD);
  - sram_state_e (IDLE/WAIT/ERR1/ERR2);
  - function lane_mask(size, addr_lsb, LB).
- One sub-module, ahb_sram_mem: parameterised DEPTH×DATA_W array with byte-enable write and asynchronous read.

Test Plan (DATA_W=32, DEPTH=256, WAIT_STATES=2 unless stated):
- Word write then read, address 0x10, data 0xDEADBEEF: each data phase shows HREADYOUT low 2 cycles then high, HRESP=00. The read returns 0xDEADBEEF.
- Byte write 0xAA to 0x13 over a word preset to 0x11223344, followed by a word read of 0x10 -> 0xAA223344.
- Unaligned halfword at 0x01, then out-of-range 0x400:
  - each gets HRESP=01 for 2 cycles with HREADYOUT 0 then 1;
  - memory is unchanged.
- WAIT_STATES=0, SEQ burst of 4 word writes at 0x20 with back-to-back reads:
  - HREADYOUT stays 1 throughout;
  - each read returns the data just written.
- HRST asserted during a WAIT cycle of a write to 0x30:
  - the next cycle shows HREADYOUT=1, HRESP=00, HRDATA=0;
  - mem[0x30] holds its old value.
- With AHB_SRAM_PROT_CHECK_EN defined, a write to 0x200 with HPROT=0001 -> ERROR and no write. The same write with HPROT=0011 -> OKAY and the write lands.

Source files
------------

// File: rtl/ahb_pkg.sv
// rtl/ahb_pkg.sv - shared AHB-Lite types and the byte-lane mask helper
//
// Purpose: enumerations for HTRANS, HRESP, HSIZE and the SRAM slave FSM,
// plus lane_mask(), which returns the little-endian byte-enable pattern for
// one beat. There are no ports.
package ahb_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;

  typedef enum logic [1:0] {
    HRESP_OKAY  = 2'b00,
    HRESP_ERROR = 2'b01
  } hresp_e;

  typedef enum logic [2:0] {
    HSIZE_BYTE  = 3'd0,
    HSIZE_HALF  = 3'd1,
    HSIZE_WORD  = 3'd2,
    HSIZE_DWORD = 3'd3
  } hsize_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_ERR1,
    ST_ERR2
  } sram_state_e;

  // The mask has 2^size ones, starting at the lane selected by the low lb
  // address bits. The result is only meaningful when size <= lb.
  function automatic logic [7:0] lane_mask(input logic [2:0] size,
                                           input logic [2:0] addr_lsb,
                                           input int         lb);
    logic [7:0] base;
    logic [2:0] lane;
    lane = addr_lsb & 3'((1 << lb) - 1);
    case (size)
      HSIZE_BYTE: base = 8'h01;
      HSIZE_HALF: base = 8'h03;
      HSIZE_WORD: base = 8'h0F;
      default:    base = 8'hFF;
    endcase
    return base << lane;
  endfunction

endpackage

// File: rtl/ahb_sram_mem.sv
// rtl/ahb_sram_mem.sv - DEPTH x DATA_W word array, byte-enable write, async read
//
// Purpose: storage behind the AHB SRAM slave. The contents are never reset.
// Ports:
//   i_clk    write clock (rising edge)
//   i_we     write enable
//   i_be     byte-lane enables, bit b covers i_wdata[8b+7:8b]
//   i_addr   word index, shared by the read and write paths
//   i_wdata  write data
//   o_rdata  combinational read of mem[i_addr]
module ahb_sram_mem #(
  parameter int DEPTH  = 256,
  parameter int DATA_W = 32
) (
  input  logic                     i_clk,
  input  logic                     i_we,
  input  logic [DATA_W/8-1:0]      i_be,
  input  logic [$clog2(DEPTH)-1:0] i_addr,
  input  logic [DATA_W-1:0]        i_wdata,
  output logic [DATA_W-1:0]        o_rdata
);

  logic [DATA_W-1:0] r_mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      for (int b = 0; b < DATA_W / 8; b++) begin
        if (i_be[b]) begin
          r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
        end
      end
    end
  end

  assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/ahb_sram_slave.sv
// rtl/ahb_sram_slave.sv - AHB-Lite SRAM slave with wait states and ERROR response
//
// Purpose: decodes the AHB-Lite address phase, inserts WAIT_STATES stall
// cycles per OKAY beat, returns a two-cycle ERROR for illegal beats, and
// commits lane-masked writes on the completing data-phase edge.
// Optional feature macro: AHB_SRAM_PROT_CHECK_EN. When it is defined, the
// upper half of memory requires HPROT[1]=1.
// Ports:
//   HCLK, HRST                  clock and synchronous active-high reset
//   HSEL, HREADY                decoder select and bus-level ready
//   HADDR, HTRANS, HWRITE       address-phase controls
//   HSIZE, HBURST, HPROT        address-phase controls (HBURST is ignored)
//   HWDATA                      write data (data phase)
//   HRDATA, HREADYOUT, HRESP    slave response
module ahb_sram_slave
  import ahb_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int DEPTH       = 256,
  parameter int WAIT_STATES = 0
) (
  input  logic              HCLK,
  input  logic              HRST,
  input  logic              HSEL,
  input  logic [ADDR_W-1:0] HADDR,
  input  logic [1:0]        HTRANS,
  input  logic              HWRITE,
  input  logic [2:0]        HSIZE,
  input  logic [2:0]        HBURST,
  input  logic [3:0]        HPROT,
  input  logic [DATA_W-1:0] HWDATA,
  input  logic              HREADY,
  output logic [DATA_W-1:0] HRDATA,
  output logic              HREADYOUT,
  output logic [1:0]        HRESP
);

  localparam int NB    = DATA_W / 8;
  localparam int LB    = $clog2(NB);
  localparam int IDX_W = $clog2(DEPTH);

  sram_state_e       r_state;
  sram_state_e       w_next_state;
  logic [3:0]        r_cnt;
  logic [3:0]        w_next_cnt;
  logic              r_write;
  logic [IDX_W-1:0]  r_idx;
  logic [NB-1:0]     r_mask;

  logic              w_accept;
  logic              w_take;
  logic              w_done;
  logic              w_err;
  logic              w_we;
  logic              w_misalign;
  logic              w_range_err;
  logic              w_prot_err;
  logic [2:0]        w_align_lo;
  logic [ADDR_W-1:0] w_word;
  logic [DATA_W-1:0] w_rdata;
  hresp_e            w_resp;

  assign w_accept = HSEL & HREADY &
                    ((HTRANS == HTRANS_NONSEQ) | (HTRANS == HTRANS_SEQ));

  // Word index of the beat. Bits above the array depth are kept so that
  // out-of-range addresses can be rejected.
  assign w_word      = HADDR >> LB;
  assign w_align_lo  = (HSIZE >= 3'd3) ? 3'b111 : 3'((4'd1 << HSIZE) - 4'd1);
  assign w_misalign  = |(HADDR[2:0] & w_align_lo);
  assign w_range_err = (w_word >= ADDR_W'(DEPTH));

`ifdef AHB_SRAM_PROT_CHECK_EN
  assign w_prot_err = (w_word >= ADDR_W'(DEPTH / 2)) & ~HPROT[1];
  logic w_unused;
  assign w_unused = &{1'b0, HBURST};
`else
  assign w_prot_err = 1'b0;
  logic w_unused;
  assign w_unused = &{1'b0, HBURST, HPROT};
`endif

  assign w_err = (HSIZE > 3'(LB)) | w_misalign | w_range_err | w_prot_err;

  always_ff @(posedge HCLK) begin
    if (HRST) begin
      r_state <= ST_IDLE;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_next_state;
      r_cnt   <= w_next_cnt;
    end
  end

  // w_take marks cycles in which HREADYOUT=1 and a new address phase may
  // be sampled: idle, the last OKAY cycle, or the second ERROR cycle.
  always_comb begin
    w_next_state = r_state;
    w_next_cnt   = r_cnt;
    HREADYOUT    = 1'b1;
    w_resp       = HRESP_OKAY;
    w_done       = 1'b0;
    w_take       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_take = 1'b1;
      end
      ST_WAIT: begin
        if (r_cnt != 4'd0) begin
          HREADYOUT  = 1'b0;
          w_next_cnt = r_cnt - 4'd1;
        end else begin
          w_done       = 1'b1;
          w_take       = 1'b1;
          w_next_state = ST_IDLE;
        end
      end
      ST_ERR1: begin
        HREADYOUT    = 1'b0;
        w_resp       = HRESP_ERROR;
        w_next_state = ST_ERR2;
      end
      ST_ERR2: begin
        w_resp       = HRESP_ERROR;
        w_take       = 1'b1;
        w_next_state = ST_IDLE;
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
    if (w_take && w_accept) begin
      w_next_state = w_err ? ST_ERR1 : ST_WAIT;
      w_next_cnt   = 4'(WAIT_STATES);
    end
  end

  always_ff @(posedge HCLK) begin
    if (HRST) begin
      r_write <= 1'b0;
      r_idx   <= '0;
      r_mask  <= '0;
    end else if (w_take && w_accept) begin
      r_write <= HWRITE;
      r_idx   <= w_word[IDX_W-1:0];
      r_mask  <= NB'(lane_mask(HSIZE, HADDR[2:0], LB));
    end
  end

  // Errored beats never reach ST_WAIT, so they can never raise w_done.
  assign w_we = w_done & r_write & ~HRST;

  ahb_sram_mem #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W)
  ) u_mem (
    .i_clk   (HCLK),
    .i_we    (w_we),
    .i_be    (r_mask),
    .i_addr  (r_idx),
    .i_wdata (HWDATA),
    .o_rdata (w_rdata)
  );

  assign HRDATA = (w_done && !r_write) ? w_rdata : '0;
  assign HRESP  = w_resp;

endmodule

// File: tb/tb_ahb_sram_slave.sv
// tb/tb_ahb_sram_slave.sv - self-checking bench for ahb_sram_slave
module tb_ahb_sram_slave;

`ifdef AHB_SRAM_PROT_CHECK_EN
  localparam bit PROT = 1'b1;
`else
  localparam bit PROT = 1'b0;
`endif

  logic        HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  logic        HRST, HSEL, HWRITE;
  logic [31:0] HADDR, HWDATA;
  logic [1:0]  HTRANS;
  logic [2:0]  HSIZE, HBURST;
  logic [3:0]  HPROT;
  logic        sel;
  logic        hsel0, hsel1, hready;
  logic [31:0] rd0, rd1;
  logic        ro0, ro1;
  logic [1:0]  rs0, rs1;

  assign hsel0  = HSEL & ~sel;
  assign hsel1  = HSEL & sel;
  assign hready = sel ? ro1 : ro0;

  ahb_sram_slave #(.ADDR_W(32), .DATA_W(32), .DEPTH(256), .WAIT_STATES(2)) u_ws2 (
    .HCLK(HCLK), .HRST(HRST), .HSEL(hsel0), .HADDR(HADDR), .HTRANS(HTRANS),
    .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST), .HPROT(HPROT),
    .HWDATA(HWDATA), .HREADY(hready), .HRDATA(rd0), .HREADYOUT(ro0), .HRESP(rs0));

  ahb_sram_slave #(.ADDR_W(32), .DATA_W(32), .DEPTH(256), .WAIT_STATES(0)) u_ws0 (
    .HCLK(HCLK), .HRST(HRST), .HSEL(hsel1), .HADDR(HADDR), .HTRANS(HTRANS),
    .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST), .HPROT(HPROT),
    .HWDATA(HWDATA), .HREADY(hready), .HRDATA(rd1), .HREADYOUT(ro1), .HRESP(rs1));

  // One expected data-phase cycle. chk: 0 = HRDATA not checked,
  // 1 = HRDATA must be 0, 2 = HRDATA must equal the model word.
  typedef struct {
    bit        rdy;
    bit [1:0]  resp;
    int        chk;
    bit        wr;
    int        idx;
    bit [3:0]  mask;
    bit [31:0] data;
  } exp_t;

  exp_t        q[$];
  bit [31:0]   mm [256];
  int          checks = 0;
  int          errors = 0;
  bit          run = 1'b0;
  int          stalls = 0;
  int          err_cycles = 0;
  logic [31:0] last_rd = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: decides OKAY/ERROR from the address rules and
  // queues the cycle-by-cycle response of the selected slave.
  task automatic model_accept(input logic [31:0] a, input logic w, input logic [2:0] sz,
                              input logic [31:0] d, input logic [3:0] pr);
    exp_t e;
    int   idx, lane, nbytes, ws;
    bit   err;
    ws     = sel ? 0 : 2;
    idx    = int'(a >> 2);
    lane   = int'(a % 4);
    nbytes = 1 << sz;
    err    = (sz > 3'd2) || ((a % nbytes) != 0) || (idx >= 256) ||
             (PROT && idx >= 128 && !pr[1]);
    e.wr = 1'b0; e.idx = idx; e.mask = '0; e.data = d;
    if (err) begin
      e.rdy = 1'b0; e.resp = 2'b01; e.chk = 1; q.push_back(e);
      e.rdy = 1'b1;                            q.push_back(e);
    end else begin
      for (int i = 0; i < ws; i++) begin
        e.rdy = 1'b0; e.resp = 2'b00; e.chk = 0; q.push_back(e);
      end
      for (int b = 0; b < 4; b++)
        if (b >= lane && b < lane + nbytes) e.mask[b] = 1'b1;
      e.rdy = 1'b1; e.resp = 2'b00; e.chk = w ? 0 : 2; e.wr = w;
      q.push_back(e);
    end
  endtask

  always @(negedge HCLK) begin
    exp_t e;
    if (run) begin
      if (q.size() > 0) e = q.pop_front();
      else begin
        e.rdy = 1'b1; e.resp = 2'b00; e.chk = 1; e.wr = 1'b0;
        e.idx = 0; e.mask = '0; e.data = '0;
      end
      check("hreadyout", {31'b0, hready}, {31'b0, e.rdy});
      check("hresp", {30'b0, sel ? rs1 : rs0}, {30'b0, e.resp});
      if (e.chk == 1) check("hrdata_zero", sel ? rd1 : rd0, 32'h0);
      if (e.chk == 2) begin
        check("hrdata", sel ? rd1 : rd0, mm[e.idx]);
        last_rd = sel ? rd1 : rd0;
      end
      if (e.wr)
        for (int b = 0; b < 4; b++)
          if (e.mask[b]) mm[e.idx][8*b +: 8] = e.data[8*b +: 8];
      if (!hready) stalls++;
      if ((sel ? rs1 : rs0) == 2'b01) err_cycles++;
      check("unsel_idle", {sel ? rd0 : rd1, 1'b0, sel ? ro0 : ro1, sel ? rs0 : rs1},
            {32'h0, 1'b0, 1'b1, 2'b00});
    end
  end

  task automatic issue(input logic [1:0] tr, input logic [31:0] a, input logic w,
                       input logic [2:0] sz, input logic [31:0] d, input logic [3:0] pr);
    bit ok;
    ok = 1'b0;
    HSEL = 1'b1; HTRANS = tr; HADDR = a; HWRITE = w; HSIZE = sz; HPROT = pr;
    for (int k = 0; k < 40; k++) begin
      @(negedge HCLK);
      if (hready) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL issue_timeout: hready 0 for 40 cycles, required 1");
    end
    @(posedge HCLK);
    if (ok && tr[1]) model_accept(a, w, sz, d, pr);
    #1 HWDATA = d;
  endtask

  task automatic go_idle(input int n);
    bit ok;
    ok = 1'b0;
    HSEL = 1'b0; HTRANS = 2'b00;
    for (int k = 0; k < 40; k++) begin
      @(negedge HCLK);
      if (hready) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL idle_timeout: hready 0 for 40 cycles, required 1");
    end
    @(posedge HCLK); #1;
    repeat (n) begin @(posedge HCLK); #1; end
  endtask

  initial begin
    HRST = 1'b1; HSEL = 1'b0; HTRANS = 2'b00; HADDR = '0; HWRITE = 1'b0;
    HSIZE = 3'd2; HBURST = 3'd1; HPROT = 4'b0011; HWDATA = '0; sel = 1'b0;
    repeat (3) @(posedge HCLK);
    #1 HRST = 1'b0;
    run = 1'b1;
    @(negedge HCLK);
    check("reset_ws2", {rd0, 1'b0, ro0, rs0}, {32'h0, 1'b0, 1'b1, 2'b00});
    check("reset_ws0", {rd1, 1'b0, ro1, rs1}, {32'h0, 1'b0, 1'b1, 2'b00});
    @(posedge HCLK); #1;

    // Word write then read with two wait states.
    stalls = 0;
    issue(2'b10, 32'h10, 1'b1, 3'd2, 32'hDEADBEEF, 4'b0011);
    go_idle(1);
    check("wr_stalls", stalls, 2);
    stalls = 0;
    issue(2'b10, 32'h10, 1'b0, 3'd2, 32'h0, 4'b0011);
    go_idle(1);
    check("rd_stalls", stalls, 2);
    check("rd_deadbeef", last_rd, 32'hDEADBEEF);

    // Byte-lane write over a preset word, then back-to-back read.
    issue(2'b10, 32'h10, 1'b1, 3'd2, 32'h11223344, 4'b0011);
    issue(2'b10, 32'h13, 1'b1, 3'd0, 32'hAA000000, 4'b0011);
    issue(2'b10, 32'h10, 1'b0, 3'd2, 32'h0, 4'b0011);
    go_idle(1);
    check("byte_merge", last_rd, 32'hAA223344);

    // ERROR responses leave memory alone; BUSY gets a plain OKAY.
    issue(2'b10, 32'h00, 1'b1, 3'd2, 32'hCAFEF00D, 4'b0011);
    go_idle(0);
    err_cycles = 0;
    issue(2'b10, 32'h01, 1'b1, 3'd1, 32'hFFFFFFFF, 4'b0011);
    issue(2'b10, 32'h400, 1'b1, 3'd2, 32'hFFFFFFFF, 4'b0011);
    issue(2'b10, 32'h08, 1'b1, 3'd3, 32'hFFFFFFFF, 4'b0011);
    issue(2'b01, 32'h04, 1'b1, 3'd2, 32'hFFFFFFFF, 4'b0011);
    issue(2'b10, 32'h00, 1'b0, 3'd2, 32'h0, 4'b0011);
    go_idle(1);
    check("err_cycles", err_cycles, 6);
    check("err_nowrite", last_rd, 32'hCAFEF00D);

    // Last valid word.
    issue(2'b10, 32'h3FC, 1'b1, 3'd2, 32'hA5A55A5A, 4'b0011);
    issue(2'b10, 32'h3FC, 1'b0, 3'd2, 32'h0, 4'b0011);
    go_idle(0);
    check("last_word", last_rd, 32'hA5A55A5A);

    // Reset during a WAIT cycle aborts the write.
    issue(2'b10, 32'h30, 1'b1, 3'd2, 32'h5555AAAA, 4'b0011);
    go_idle(0);
    issue(2'b10, 32'h30, 1'b1, 3'd2, 32'h12345678, 4'b0011);
    HSEL = 1'b0; HTRANS = 2'b00;
    @(posedge HCLK); #1;
    HRST = 1'b1;
    @(posedge HCLK);
    q.delete();
    #1 HRST = 1'b0;
    @(negedge HCLK);
    check("post_reset", {rd0, 1'b0, ro0, rs0}, {32'h0, 1'b0, 1'b1, 2'b00});
    @(posedge HCLK); #1;
    issue(2'b10, 32'h30, 1'b0, 3'd2, 32'h0, 4'b0011);
    go_idle(0);
    check("reset_nowrite", last_rd, 32'h5555AAAA);

    // Privileged upper half (active only with the protection feature).
    issue(2'b10, 32'h200, 1'b1, 3'd2, 32'h600DCAFE, 4'b0011);
    go_idle(0);
    err_cycles = 0;
    issue(2'b10, 32'h200, 1'b1, 3'd2, 32'h0BAD0BAD, 4'b0001);
    issue(2'b10, 32'h200, 1'b0, 3'd2, 32'h0, 4'b0011);
    go_idle(0);
    check("prot_err_cycles", err_cycles, PROT ? 2 : 0);
    check("prot_user_wr", last_rd, PROT ? 32'h600DCAFE : 32'h0BAD0BAD);
    issue(2'b10, 32'h200, 1'b1, 3'd2, 32'h13579BDF, 4'b0011);
    issue(2'b10, 32'h200, 1'b0, 3'd2, 32'h0, 4'b0011);
    go_idle(1);
    check("prot_priv_wr", last_rd, 32'h13579BDF);

    // Zero-wait slave: SEQ burst, back-to-back reads, write/read hazard.
    sel = 1'b1;
    @(posedge HCLK); #1;
    stalls = 0;
    for (int i = 0; i < 4; i++)
      issue(i == 0 ? 2'b10 : 2'b11, 32'h20 + 4 * i, 1'b1, 3'd2, 32'h01020304 * (i + 1), 4'b0011);
    for (int i = 0; i < 4; i++)
      issue(i == 0 ? 2'b10 : 2'b11, 32'h20 + 4 * i, 1'b0, 3'd2, 32'h0, 4'b0011);
    issue(2'b10, 32'h40, 1'b1, 3'd2, 32'h89ABCDEF, 4'b0011);
    issue(2'b10, 32'h40, 1'b0, 3'd2, 32'h0, 4'b0011);
    go_idle(0);
    check("ws0_stalls", stalls, 0);
    check("ws0_fwd", last_rd, 32'h89ABCDEF);
    issue(2'b10, 32'h42, 1'b1, 3'd2, 32'h0, 4'b0011);
    issue(2'b10, 32'h40, 1'b0, 3'd2, 32'h0, 4'b0011);
    go_idle(2);
    check("ws0_err_nowrite", last_rd, 32'h89ABCDEF);

    run = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
